// File: rtl/alu_response_checker.sv
// Self-check monitor for the MIPS datapath ALU: recomputes each result with a
// reference model, compares over two pipeline stages and keeps run statistics.
module alu_response_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [31:0]      rsdata,
  input  logic [31:0]      rtdataOrextimm,
  input  logic [3:0]       ALUctrl,
  input  logic [31:0]      ALUResult,
  input  logic             zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             err_valid,
  output logic [3:0]       err_ctrl,
  output logic [31:0]      err_expected,
  output logic [31:0]      err_actual
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;
  logic   drain_cnt;
  logic   arm;
  logic   accept;

  logic [31:0] model_result;
  logic        model_legal;

  logic        s1_valid;
  logic        s1_legal;
  logic [3:0]  s1_ctrl;
  logic [31:0] s1_expected;
  logic [31:0] s1_actual;
  logic        s1_zero;
  logic        mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DRAIN) drain_cnt <= ~drain_cnt;
      else                drain_cnt <= 1'b0;
    end
  end

  // DRAIN holds two cycles so the transaction accepted with stop retires.
  always_comb begin
    state_next = state;
    arm        = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_next = RUN;
        arm        = 1'b1;
      end
      RUN: if (stop) state_next = DRAIN;
      DRAIN: if (drain_cnt) state_next = DONE;
      DONE: if (start) begin
        state_next = RUN;
        arm        = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid && (state == RUN);
  assign busy   = (state == RUN) || (state == DRAIN);
  assign done   = (state == DONE);
  assign pass   = done && (err_cnt == '0) && (check_cnt != '0);

  always_comb begin
    model_result = 32'd0;
    model_legal  = 1'b1;
    case (ALUctrl)
      4'd0: model_result = rsdata & rtdataOrextimm;
      4'd1: model_result = rsdata | rtdataOrextimm;
      4'd2: model_result = rsdata + rtdataOrextimm;
      4'd6: model_result = rsdata - rtdataOrextimm;
      4'd7: model_result = {31'd0, ($signed(rsdata) < $signed(rtdataOrextimm))};
      default: model_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_legal    <= 1'b0;
      s1_ctrl     <= 4'd0;
      s1_expected <= 32'd0;
      s1_actual   <= 32'd0;
      s1_zero     <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_legal    <= model_legal;
        s1_ctrl     <= ALUctrl;
        s1_expected <= model_result;
        s1_actual   <= ALUResult;
        s1_zero     <= zero;
      end
    end
  end

  assign mismatch = (s1_expected != s1_actual) || ((s1_expected == 32'd0) != s1_zero);

  // Arming a new run wipes the statistics; only the first mismatch is recorded.
  always_ff @(posedge clk) begin
    if (reset || arm) begin
      check_cnt    <= '0;
      err_cnt      <= '0;
      illegal_cnt  <= '0;
      err_valid    <= 1'b0;
      err_ctrl     <= 4'd0;
      err_expected <= 32'd0;
      err_actual   <= 32'd0;
    end else if (s1_valid) begin
      if (s1_legal) begin
        if (check_cnt != CNT_MAX) check_cnt <= check_cnt + CNT_ONE;
        if (mismatch) begin
          if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
          if (!err_valid) begin
            err_valid    <= 1'b1;
            err_ctrl     <= s1_ctrl;
            err_expected <= s1_expected;
            err_actual   <= s1_actual;
          end
        end
      end else if (illegal_cnt != CNT_MAX) begin
        illegal_cnt <= illegal_cnt + CNT_ONE;
      end
    end
  end

endmodule
